// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered read data, occupancy and flags.
// Optional sticky overflow/underflow flags are enabled by defining SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       tx_ready,
   input  logic [DATA_W-1:0]          tx_data,
   input  logic                       rx_ready,
   output logic [DATA_W-1:0]          rx_data,
   output logic                       rx_valid,
   output logic                       fifo_f,
   output logic                       fifo_e,
   output logic                       fifo_af,
   output logic                       fifo_ae,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf_err,
   output logic                       udf_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [LW-1:0] LVL_ONE = LW'(1);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [LW-1:0]     level_r;
   logic [LW-1:0]     level_nxt_s;
   logic [DATA_W-1:0] rx_data_r;
   logic              rx_valid_r;
   logic              full_r;
   logic              empty_r;
   logic              af_r;
   logic              ae_r;
   logic              wr_acc_s;
   logic              rd_acc_s;

   // Handshake: a read frees a slot in the same cycle, so a full FIFO still takes a write.
   always_comb begin
      rd_acc_s = rx_ready && !empty_r;
      wr_acc_s = tx_ready && (!full_r || rd_acc_s);
   end

   // Next occupancy; simultaneous read and write leaves it unchanged.
   always_comb begin
      level_nxt_s = level_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Storage array; contents are not reset.
   always_ff @(posedge sys_clk) begin
      if (wr_acc_s && !rst) begin
         mem_r[wr_ptr_r] <= tx_data;
      end
   end

   // Pointers, read data, occupancy and flags registered from the next-state level.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {LW{1'b0}};
         rx_data_r  <= {DATA_W{1'b0}};
         rx_valid_r <= 1'b0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         af_r       <= 1'b0;
         ae_r       <= 1'b1;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_acc_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            rx_data_r <= mem_r[rd_ptr_r];
         end
         rx_valid_r <= rd_acc_s;
         level_r    <= level_nxt_s;
         full_r     <= (level_nxt_s == LW'(DEPTH));
         empty_r    <= (level_nxt_s == {LW{1'b0}});
         af_r       <= (level_nxt_s >= LW'(AF_THRESH));
         ae_r       <= (level_nxt_s <= LW'(AE_THRESH));
      end
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic ovf_err_r;
   logic udf_err_r;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         ovf_err_r <= 1'b0;
         udf_err_r <= 1'b0;
      end else begin
         if (tx_ready && full_r && !rd_acc_s) begin
            ovf_err_r <= 1'b1;
         end
         if (rx_ready && empty_r) begin
            udf_err_r <= 1'b1;
         end
      end
   end

   assign ovf_err = ovf_err_r;
   assign udf_err = udf_err_r;
`else
   assign ovf_err = 1'b0;
   assign udf_err = 1'b0;
`endif

   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign level    = level_r;
   assign fifo_f   = full_r;
   assign fifo_e   = empty_r;
   assign fifo_af  = af_r;
   assign fifo_ae  = ae_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sync_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int AF_T   = DEPTH - 2;
   localparam int AE_T   = 2;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              sys_clk = 1'b0;
   logic              rst = 1'b1;
   logic              tx_ready = 1'b0;
   logic [DATA_W-1:0] tx_data = 8'h00;
   logic              rx_ready = 1'b0;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              fifo_f, fifo_e, fifo_af, fifo_ae;
   logic [3:0]        level;
   logic              ovf_err, udf_err;

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_T), .AE_THRESH(AE_T)) dut (
      .sys_clk(sys_clk), .rst(rst), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .fifo_f(fifo_f), .fifo_e(fifo_e), .fifo_af(fifo_af), .fifo_ae(fifo_ae),
      .level(level), .ovf_err(ovf_err), .udf_err(udf_err)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Reference model: contents as a queue, outputs derived from its size.
   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] m_data = 8'h00;
   logic              m_valid = 1'b0;
   logic              m_ovf = 1'b0;
   logic              m_udf = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   always @(posedge sys_clk) begin
      bit rd, wr;
      if (rst) begin
         q.delete();
         m_data  = 8'h00;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
      end else begin
         rd = rx_ready && (q.size() > 0);
         wr = tx_ready && ((q.size() < DEPTH) || rd);
         if (ERR_EN && tx_ready && (q.size() == DEPTH) && !rd) m_ovf = 1'b1;
         if (ERR_EN && rx_ready && (q.size() == 0)) m_udf = 1'b1;
         m_valid = rd;
         if (rd) m_data = q.pop_front();
         if (wr) q.push_back(tx_data);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge sys_clk) begin
      int sz;
      if (chk_en) begin
         sz = q.size();
         check("rx_valid", int'(rx_valid), int'(m_valid));
         check("rx_data", int'(rx_data), int'(m_data));
         check("level", int'(level), sz);
         check("fifo_f", int'(fifo_f), int'(sz == DEPTH));
         check("fifo_e", int'(fifo_e), int'(sz == 0));
         check("fifo_af", int'(fifo_af), int'(sz >= AF_T));
         check("fifo_ae", int'(fifo_ae), int'(sz <= AE_T));
         check("ovf_err", int'(ovf_err), int'(m_ovf));
         check("udf_err", int'(udf_err), int'(m_udf));
      end
   end

   task automatic cyc(input logic t, input logic [DATA_W-1:0] d, input logic r, input logic rs);
      tx_ready = t;
      tx_data  = d;
      rx_ready = r;
      rst      = rs;
      @(negedge sys_clk);
   endtask

   initial begin
      @(negedge sys_clk);
      cyc(1'b1, 8'h00, 1'b1, 1'b1);
      chk_en = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("rst_level", int'(level), 0);
      check("rst_e", int'(fifo_e), 1);
      check("rst_f", int'(fifo_f), 0);
      check("rst_ae", int'(fifo_ae), 1);
      check("rst_af", int'(fifo_af), 0);
      check("rst_valid", int'(rx_valid), 0);
      check("rst_data", int'(rx_data), 0);

      // Fill with 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 5) check("af_at5", int'(fifo_af), 0);
         if (i == 6) check("af_at6", int'(fifo_af), 1);
      end
      check("full_level", int'(level), 8);
      check("full_f", int'(fifo_f), 1);

      // Rejected write while full
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      check("ovf_level", int'(level), 8);
      check("ovf_flag", int'(ovf_err), int'(ERR_EN));

      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         check("rd_valid", int'(rx_valid), 1);
         check("rd_order", int'(rx_data), i);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      check("drain_e", int'(fifo_e), 1);
      check("hold_valid", int'(rx_valid), 0);
      check("hold_data", int'(rx_data), 8'h08);

      // Simultaneous read+write while empty
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      check("emp_rw_valid", int'(rx_valid), 0);
      check("emp_rw_level", int'(level), 1);
      check("udf_flag", int'(udf_err), int'(ERR_EN));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("emp_rw_data", int'(rx_data), 8'h55);

      // Full with streaming read+write across pointer wraps
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 8'h99, 1'b1, 1'b0);
         check("stream_level", int'(level), 8);
         check("stream_f", int'(fifo_f), 1);
         check("stream_data", int'(rx_data), (i < 8) ? (8'h10 + i) : 8'h99);
      end
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         check("stream_tail", int'(rx_data), 8'h99);
      end

      // Reset mid-transfer at level 5
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      check("pre_rst_level", int'(level), 5);
      cyc(1'b1, 8'h77, 1'b1, 1'b1);
      check("mid_rst_level", int'(level), 0);
      check("mid_rst_e", int'(fifo_e), 1);
      check("mid_rst_valid", int'(rx_valid), 0);
      check("mid_rst_ovf", int'(ovf_err), 0);
      check("mid_rst_udf", int'(udf_err), 0);
      cyc(1'b1, 8'h33, 1'b0, 1'b0);
      check("post_rst_level", int'(level), 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("post_rst_data", int'(rx_data), 8'h33);

      // Randomized traffic with varying bias and occasional resets
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = (i / 500) % 3;
         cyc(($urandom_range(9, 0) < 3 + 2 * bias) ? 1'b1 : 1'b0,
             8'($urandom),
             ($urandom_range(9, 0) < 7 - 2 * bias) ? 1'b1 : 1'b0,
             ($urandom_range(399, 0) == 0) ? 1'b1 : 1'b0);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
